// File: rtl/censor_pkg.sv
// Shared constants and FSM state encoding for the censor UART output stage.
package censor_pkg;

  localparam int CHAR_W          = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/censor_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; a push into a full FIFO
// is accepted only when a pop frees the slot on the same edge.
module censor_sync_fifo #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ZERO_LVL = {(ADDR_W+1){1'b0}};

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (level_r == FULL_LVL);
  assign empty     = (level_r == ZERO_LVL);
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage array; data needs no reset because level gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= ZERO_LVL;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/censor_uart_tx.sv
// Buffers the censored character stream and serialises it as 8N1 UART frames,
// chaining frames back-to-back while characters remain queued.
module censor_uart_tx
  import censor_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  parameter  int FIFO_DEPTH   = 16,
  localparam int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        char_in,
  input  logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [2:0]        BIT_LAST  = 3'(CHAR_W - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]        state_r,  state_n_s;
  logic [BAUD_W-1:0] baud_r,   baud_n_s;
  logic [2:0]        bit_r,    bit_n_s;
  logic [CHAR_W-1:0] shift_r,  shift_n_s;
  logic              tx_r,     tx_n_s;
  logic              busy_r,   busy_n_s;
  logic              overflow_r;
  logic              pop_s;
  logic              baud_done_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CHAR_W-1:0] fifo_head_s;

  censor_sync_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (data_ready),
    .pop   (pop_s),
    .din   (char_in),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign baud_done_s = (baud_r == BAUD_LAST);
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign overflow    = overflow_r;

  // Frame sequencer; tx/busy next values are computed here so they register cleanly.
  always_comb begin
    state_n_s = state_r;
    baud_n_s  = baud_r;
    bit_n_s   = bit_r;
    shift_n_s = shift_r;
    tx_n_s    = tx_r;
    busy_n_s  = busy_r;
    pop_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          shift_n_s = fifo_head_s;
          pop_s     = 1'b1;
          state_n_s = S_START;
          baud_n_s  = BAUD_ZERO;
          tx_n_s    = 1'b0;
          busy_n_s  = 1'b1;
        end else begin
          tx_n_s    = 1'b1;
          busy_n_s  = 1'b0;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          state_n_s = S_DATA;
          baud_n_s  = BAUD_ZERO;
          bit_n_s   = 3'd0;
          tx_n_s    = shift_r[0];
        end else begin
          baud_n_s  = baud_r + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          baud_n_s = BAUD_ZERO;
          if (bit_r == BIT_LAST) begin
            state_n_s = S_STOP;
            tx_n_s    = 1'b1;
          end else begin
            bit_n_s   = bit_r + 1'b1;
            shift_n_s = shift_r >> 1;
            tx_n_s    = shift_r[1];
          end
        end else begin
          baud_n_s = baud_r + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done_s) begin
          baud_n_s = BAUD_ZERO;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty_s) begin
            shift_n_s = fifo_head_s;
            pop_s     = 1'b1;
            state_n_s = S_START;
            tx_n_s    = 1'b0;
            busy_n_s  = 1'b1;
          end else begin
            state_n_s = S_IDLE;
            tx_n_s    = 1'b1;
            busy_n_s  = 1'b0;
          end
        end else begin
          baud_n_s = baud_r + 1'b1;
        end
      end
      default: begin
        state_n_s = S_IDLE;
        baud_n_s  = BAUD_ZERO;
        bit_n_s   = 3'd0;
        tx_n_s    = 1'b1;
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= {CHAR_W{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      baud_r  <= baud_n_s;
      bit_r   <= bit_n_s;
      shift_r <= shift_n_s;
      tx_r    <= tx_n_s;
      busy_r  <= busy_n_s;
    end
  end

  // Sticky loss flag: a push hit a full FIFO with no pop to make room.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (data_ready && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule
